// File: rtl/ncc_pkg.sv
// rtl/ncc_pkg.sv - shared types and width helper for the ncc frame sequencer
//
// Holds the sequencer state encoding, the accumulator width function used to
// size every sum port, and a result record sized for the default geometry.
package ncc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_HOLD
  } ncc_state_e;

  // Width needed to hold a window sum of squared pixels without overflow.
  function automatic int ncc_acc_w(input int num_lines, input int line_size,
                                   input int pixel_size);
    return $clog2(num_lines) + $clog2(line_size) + 2 * pixel_size;
  endfunction

  localparam int NCC_PIXEL_SIZE    = 8;
  localparam int NCC_LINE_SIZE     = 8;
  localparam int NCC_NUM_TEMPLATES = 4;
  localparam int NCC_NUM_OF_LINES  = 8;
  localparam int NCC_ACC_W = ncc_acc_w(NCC_NUM_OF_LINES, NCC_LINE_SIZE, NCC_PIXEL_SIZE);

  typedef struct packed {
    logic [NCC_ACC_W-1:0]                        sum_I;
    logic [NCC_ACC_W-1:0]                        sum_I_sq;
    logic [NCC_NUM_TEMPLATES-1:0][NCC_ACC_W-1:0] sum_TxI;
  } ncc_result_t;

endpackage

// File: rtl/ncc_frame_sequencer.sv
// rtl/ncc_frame_sequencer.sv - match-window sequencer for the ncc accumulation datapath
//
// Sequences one window: clear accumulators, admit NUM_OF_LINES lines, wait out
// the datapath latency, capture the sums and hold them until taken.
//   CLK, reset_n           clock, asynchronous active-low reset
//   start, abort           window request / synchronous return to idle
//   line_valid/line_ready  line handshake with the source
//   acc_clr, acc_en        accumulator clear and line-sample strobes
//   line_idx, busy         index of line being accepted, window in progress
//   acc_sum_*              sums from the datapath
//   res_sum_*              captured sums, res_valid/res_ready handshake
module ncc_frame_sequencer
  import ncc_pkg::*;
#(
  parameter int PIXEL_SIZE    = 8,
  parameter int LINE_SIZE     = 8,
  parameter int NUM_TEMPLATES = 4,
  parameter int NUM_OF_LINES  = 8,
  parameter int PIPE_LAT      = 3,
  localparam int ACC_W = ncc_acc_w(NUM_OF_LINES, LINE_SIZE, PIXEL_SIZE),
  localparam int IDX_W = $clog2(NUM_OF_LINES)
) (
  input  logic                                CLK,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                line_valid,
  output logic                                line_ready,
  output logic                                acc_clr,
  output logic                                acc_en,
  output logic [IDX_W-1:0]                    line_idx,
  output logic                                busy,
  input  logic [ACC_W-1:0]                    acc_sum_I,
  input  logic [ACC_W-1:0]                    acc_sum_I_sq,
  input  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] acc_sum_TxI,
  output logic [ACC_W-1:0]                    res_sum_I,
  output logic [ACC_W-1:0]                    res_sum_I_sq,
  output logic [NUM_TEMPLATES-1:0][ACC_W-1:0] res_sum_TxI,
  output logic                                res_valid,
  input  logic                                res_ready
);

  // Sized from PIPE_LAT+1 so a single-cycle drain still gets a 1-bit counter.
  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

  ncc_state_e         state_q, state_d;
  logic [IDX_W-1:0]   line_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic               line_hs;
  logic               last_line;
  logic               drain_done;
  logic               capture;

  assign line_ready = (state_q == ST_FEED);
  assign acc_en     = line_valid & line_ready;
  assign acc_clr    = (state_q == ST_CLEAR);
  assign busy       = (state_q != ST_IDLE);
  assign res_valid  = (state_q == ST_HOLD);
  assign line_idx   = line_ready ? line_cnt_q : '0;

  assign line_hs    = acc_en;
  assign last_line  = (line_cnt_q == IDX_W'(NUM_OF_LINES - 1));
  assign drain_done = (state_q == ST_DRAIN) && (drain_cnt_q == '0);
  // An abort landing on the capture edge must leave the previous result intact.
  assign capture    = drain_done & ~abort;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED:  if (line_hs && last_line) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_q == '0) state_d = ST_HOLD;
      ST_HOLD:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else if (abort) begin
      line_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: line_cnt_q <= '0;
        ST_FEED: begin
          if (line_hs) begin
            if (last_line) begin
              line_cnt_q  <= '0;
              drain_cnt_q <= DRAIN_W'(PIPE_LAT - 1);
            end else begin
              line_cnt_q <= line_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Result register only loads on capture; it keeps its contents across
  // abort so a consumer never sees a partially accumulated window.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      res_sum_I    <= '0;
      res_sum_I_sq <= '0;
      res_sum_TxI  <= '0;
    end else if (capture) begin
      res_sum_I    <= acc_sum_I;
      res_sum_I_sq <= acc_sum_I_sq;
      res_sum_TxI  <= acc_sum_TxI;
    end
  end

endmodule
